// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing MainMemory (mem_*) between an instruction read port (i_*) and a data read/write port (d_*)
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2;
  logic [1:0] state;
  logic last_d, wr_q, d_req, pick_i, pick_d, g_i, g_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign d_req  = d_read | d_write;
  assign pick_i = i_read & (~d_req | last_d);
  assign pick_d = d_req & (~i_read | ~last_d);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_i) begin
        state   <= GRANT_I;
        last_d  <= 1'b0;
        addr_q  <= i_addr;
        wdata_q <= '0;
        wr_q    <= 1'b0;
      end else if (pick_d) begin
        state   <= GRANT_D;
        last_d  <= 1'b1;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        wr_q    <= d_write;
      end
    end else if (mem_ready) begin
      state <= IDLE;
    end
  end
  always_comb begin
    g_i       = ~rst & (state == GRANT_I);
    g_d       = ~rst & (state == GRANT_D);
    busy      = g_i | g_d;
    mem_read  = g_i | (g_d & ~wr_q);
    mem_write = g_d & wr_q;
    mem_addr  = rst ? '0 : addr_q;
    mem_wdata = rst ? '0 : wdata_q;
    i_ready   = g_i & mem_ready;
    d_ready   = g_d & mem_ready;
    i_rdata   = i_ready ? mem_rdata : '0;
    d_rdata   = d_ready ? mem_rdata : '0;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 i_read  in  1  instruction-side read request; held until i_ready.
REQ-006 i_addr  in  ADDR_W  instruction-side address.
REQ-007 i_rdata  out  DATA_W  instruction-side read data, valid when i_ready.
REQ-008 i_ready  out  1  instruction-side completion pulse.
REQ-009 d_read  in  1  data-side read request; held until d_ready.
REQ-010 d_write  in  1  data-side write request; held until d_ready.
REQ-011 d_addr  in  ADDR_W  data-side address.
REQ-012 d_wdata  in  DATA_W  data-side write data.
REQ-013 d_rdata  out  DATA_W  data-side read data, valid when d_ready.
REQ-014 d_ready  out  1  data-side completion pulse.
REQ-015 mem_read  out  1  read command to MainMemory.
REQ-016 mem_write  out  1  write command to MainMemory.
REQ-017 mem_addr  out  ADDR_W  address to MainMemory.
REQ-018 mem_wdata  out  DATA_W  write data to MainMemory.
REQ-019 mem_rdata  in  DATA_W  read data from MainMemory, valid with mem_ready.
REQ-020 mem_ready  in  1  MainMemory completion, one-cycle pulse.
REQ-021 busy  out  1  high while a transaction is granted.

Function
REQ-022 FSM states: IDLE, GRANT_I, GRANT_D; encoded state register only.
REQ-023 IDLE: i_read only -> GRANT_I; (d_read|d_write) only -> GRANT_D; neither -> stay.
REQ-024 IDLE, both sides requesting: grant side opposite to last_grant (round-robin); last_grant updated on every grant.
REQ-025 On grant, latch address, wdata and op (read/write) into registers; mem_* driven only from latched values, stable until mem_ready.
REQ-026 d_read and d_write both high at grant: op latched as write.
REQ-027 Request-input changes during a granted transaction: ignored.
REQ-028 mem_read/mem_write asserted every cycle in GRANT_I/GRANT_D until mem_ready; GRANT_I never asserts mem_write.
REQ-029 mem_ready in GRANT_x: x_ready = 1 combinationally same cycle, x_rdata = mem_rdata; FSM -> IDLE next edge.
REQ-030 Ungranted side: x_ready = 0, x_rdata = 0.
REQ-031 mem_ready in IDLE: ignored, no ready pulse.
REQ-032 Latency: request seen at edge N -> mem command from cycle N+1; ready in cycle of mem_ready; one IDLE cycle minimum between transactions.
REQ-033 Request still high in IDLE after its ready: treated as new transaction.
REQ-034 busy = 1 in GRANT_I/GRANT_D, 0 in IDLE.
REQ-035 No starvation: with both sides continuously requesting, grants alternate I, D, I, D.

Reset
REQ-036 rst high at edge: state = IDLE, last_grant = D (I wins first tie), latched addr/wdata/op = 0.
REQ-037 All outputs 0 during and after reset until next grant.
REQ-038 Reset mid-transaction: transaction abandoned, no ready pulse, mem_read/mem_write 0 next cycle; stale mem_ready after reset ignored.

Verification
REQ-039 i_read, i_addr=0x100; mem_ready 3 cycles after mem_read, mem_rdata=0xDEADBEEF -> mem_addr=0x100, i_ready 1 cycle, i_rdata=0xDEADBEEF, d_ready=0.
REQ-040 d_write, d_addr=0x200, d_wdata=0x12345678 -> mem_write=1, mem_addr=0x200, mem_wdata=0x12345678 until mem_ready; d_ready 1 cycle; mem_read never 1.
REQ-041 After reset, i_read and d_read raised same cycle, held continuously -> grants I, D, I, D; mem_addr alternates accordingly.
REQ-042 During GRANT_D, change d_addr 0x200 -> 0x300 -> mem_addr stays 0x200 until mem_ready.
REQ-043 rst asserted while GRANT_I awaiting mem_ready -> next cycle state IDLE, mem_read=0, i_ready never pulses; later mem_ready pulse ignored.
REQ-044 d_read and d_write both high -> write performed (mem_write=1, mem_read=0).
